// File: rtl/bpred_pkg.sv
// bpred_pkg: counter type, FSM states and saturating-counter helper for bpred_ctrl
package bpred_pkg;
  typedef logic [1:0] ctr_t;
  typedef enum logic {INIT, RUN} state_t;
  localparam ctr_t SNT = 2'b00;
  localparam ctr_t WNT = 2'b01;
  localparam ctr_t WT  = 2'b10;
  localparam ctr_t ST  = 2'b11;
  function automatic ctr_t ctr_next(input ctr_t c, input logic taken);
    return taken ? (c == ST ? ST : c + 2'd1) : (c == SNT ? SNT : c - 2'd1);
  endfunction
endpackage

// File: rtl/bpred_upd_fifo.sv
// bpred_upd_fifo: in-order update queue with synchronous clear
module bpred_upd_fifo #(
  parameter int DEPTH = 2,
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);
  logic [W-1:0] mem [DEPTH];
  logic [PW-1:0] rd, wr;
  logic [CW-1:0] cnt;
  assign full = cnt == CW'(DEPTH);
  assign empty = cnt == '0;
  assign dout = mem[rd];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rd <= '0;
      wr <= '0;
      cnt <= '0;
    end else if (clr) begin
      rd <= '0;
      wr <= '0;
      cnt <= '0;
    end else begin
      if (push) wr <= wr == LAST ? '0 : wr + 1'b1;
      if (pop) rd <= rd == LAST ? '0 : rd + 1'b1;
      cnt <= cnt + CW'(push) - CW'(pop);
    end
  always_ff @(posedge clk)
    if (push) mem[wr] <= din;
endmodule

// File: rtl/bpred_ctrl.sv
// bpred_ctrl: 2-bit counter branch predictor with init sweep and queued updates
// Define BPRED_BYPASS_EN to forward a same-cycle table write to the prediction read.
module bpred_ctrl import bpred_pkg::*; #(
  parameter int ENTRIES = 16,
  parameter ctr_t INIT_STATE = 2'b11,
  parameter int FIFO_DEPTH = 2,
  localparam int IDX_W = $clog2(ENTRIES)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             pred_valid,
  input  logic [IDX_W-1:0] pred_idx,
  output logic             pred_ready,
  output logic             pred_resp_valid,
  output logic             pred_taken,
  input  logic             upd_valid,
  input  logic [IDX_W-1:0] upd_idx,
  input  logic             upd_taken,
  output logic             upd_ready,
  output logic             busy
);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(ENTRIES - 1);
  state_t state, state_nx;
  logic [IDX_W-1:0] ptr, ptr_nx, hd_idx;
  logic [IDX_W:0] hd;
  ctr_t tbl [ENTRIES];
  ctr_t wr_val;
  logic run, push, pop, full, empty, hd_taken, rd_bit;
  assign run = state == RUN && !flush;
  assign pred_ready = run;
  assign upd_ready = run && !full;
  assign push = upd_valid && upd_ready;
  assign pop = run && !empty;
  assign busy = state == INIT || !empty;
  assign hd_idx = hd[IDX_W:1];
  assign hd_taken = hd[0];
  assign wr_val = ctr_next(tbl[hd_idx], hd_taken);
`ifdef BPRED_BYPASS_EN
  assign rd_bit = pop && hd_idx == pred_idx ? wr_val[1] : tbl[pred_idx][1];
`else
  assign rd_bit = tbl[pred_idx][1];
`endif
  bpred_upd_fifo #(.DEPTH(FIFO_DEPTH), .W(IDX_W + 1)) u_fifo (
    .clk(clk),
    .rst_n(rst_n),
    .clr(flush),
    .push(push),
    .pop(pop),
    .din({upd_idx, upd_taken}),
    .dout(hd),
    .full(full),
    .empty(empty)
  );
  always_comb begin
    state_nx = flush ? INIT : (state == INIT && ptr == LAST) ? RUN : state;
    ptr_nx = flush || state == RUN ? '0 : ptr + 1'b1;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= INIT;
      ptr <= '0;
    end else begin
      state <= state_nx;
      ptr <= ptr_nx;
    end
  // table has no reset; the sweep owns it in INIT, the FIFO head in RUN
  always_ff @(posedge clk)
    if (state == INIT) tbl[ptr] <= INIT_STATE;
    else if (pop) tbl[hd_idx] <= wr_val;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      pred_resp_valid <= 1'b0;
      pred_taken <= 1'b0;
    end else begin
      pred_resp_valid <= pred_valid && pred_ready;
      if (pred_valid && pred_ready) pred_taken <= rd_bit;
    end
endmodule

// File: tb/tb_bpred_ctrl.sv
// tb_bpred_ctrl: randomized self-checking bench for bpred_ctrl against a counter-table model
module tb_bpred_ctrl;
  logic clk = 1'b0;
  logic rst_n, flush, pred_valid, upd_valid, upd_taken;
  logic [3:0] pred_idx, upd_idx;
  logic pred_ready, pred_resp_valid, pred_taken, upd_ready, busy;
  int errs = 0;
  int checks = 0;
  int ref_tbl [16];

  bpred_ctrl dut (
    .clk(clk),
    .rst_n(rst_n),
    .flush(flush),
    .pred_valid(pred_valid),
    .pred_idx(pred_idx),
    .pred_ready(pred_ready),
    .pred_resp_valid(pred_resp_valid),
    .pred_taken(pred_taken),
    .upd_valid(upd_valid),
    .upd_idx(upd_idx),
    .upd_taken(upd_taken),
    .upd_ready(upd_ready),
    .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  function automatic int sat(input int v, input bit t);
    return t ? (v >= 3 ? 3 : v + 1) : (v <= 0 ? 0 : v - 1);
  endfunction

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic ref_fill;
    for (int i = 0; i < 16; i++) ref_tbl[i] = 3;
  endtask

  task automatic drain;
    int n = 0;
    while (busy && n < 200) begin
      cyc();
      n++;
    end
    checks++;
    if (busy !== 1'b0) begin
      errs++;
      $display("FAIL drain: busy=%b required 0 within 200 cycles", busy);
    end
  endtask

  task automatic do_pred(input int idx, output logic t);
    int n = 0;
    pred_valid = 1'b1;
    pred_idx = 4'(idx);
    while (!pred_ready && n < 200) begin
      cyc();
      n++;
    end
    cyc();
    pred_valid = 1'b0;
    checks++;
    if (pred_resp_valid !== 1'b1) begin
      errs++;
      $display("FAIL pred_resp idx=%0d: pred_resp_valid=%b required 1", idx, pred_resp_valid);
    end
    t = pred_taken;
  endtask

  task automatic do_upd(input int idx, input bit t);
    int n = 0;
    upd_valid = 1'b1;
    upd_idx = 4'(idx);
    upd_taken = t;
    while (!upd_ready && n < 200) begin
      cyc();
      n++;
    end
    cyc();
    upd_valid = 1'b0;
    ref_tbl[idx] = sat(ref_tbl[idx], t);
  endtask

  task automatic expect_pred(input string name, input int idx);
    logic t;
    do_pred(idx, t);
    checks++;
    if (t !== logic'(ref_tbl[idx] >= 2)) begin
      errs++;
      $display("FAIL %s idx=%0d: pred_taken=%b required %b", name, idx, t, ref_tbl[idx] >= 2);
    end
  endtask

  task automatic check_all(input string name);
    for (int i = 0; i < 16; i++) expect_pred(name, i);
  endtask

  task automatic check_sweep(input string name);
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (pred_ready !== 1'b0 || busy !== 1'b1) begin
        errs++;
        $display("FAIL %s cycle %0d: pred_ready=%b busy=%b required 0/1", name, i, pred_ready, busy);
      end
      cyc();
    end
    checks++;
    if (pred_ready !== 1'b1) begin
      errs++;
      $display("FAIL %s end: pred_ready=%b required 1", name, pred_ready);
    end
    ref_fill();
  endtask

  task automatic check_reset_outputs(input string name);
    checks++;
    if ({pred_ready, upd_ready, busy, pred_resp_valid, pred_taken} !== 5'b00100) begin
      errs++;
      $display("FAIL %s: ready/upd_ready/busy/resp/taken=%b required 00100", name,
               {pred_ready, upd_ready, busy, pred_resp_valid, pred_taken});
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    flush = 1'b0;
    pred_valid = 1'b0;
    pred_idx = '0;
    upd_valid = 1'b0;
    upd_idx = '0;
    upd_taken = 1'b0;
    #3;
    check_reset_outputs("reset_outputs");
    cyc();
    rst_n = 1'b1;
    check_sweep("reset_sweep");
    expect_pred("reset_idx5", 5);
  endtask

  task automatic test_counter;
    for (int i = 0; i < 3; i++) do_upd(3, 1'b0);
    drain();
    expect_pred("ctr_3nt", 3);
    do_upd(3, 1'b1);
    drain();
    expect_pred("ctr_1t", 3);
    do_upd(3, 1'b1);
    drain();
    expect_pred("ctr_2t", 3);
  endtask

  task automatic test_saturation;
    for (int i = 0; i < 4; i++) do_upd(7, 1'b1);
    drain();
    expect_pred("sat_hi4", 7);
    for (int i = 0; i < 3; i++) do_upd(7, 1'b1);
    do_upd(7, 1'b0);
    drain();
    expect_pred("sat_hi_then_nt", 7);
    for (int i = 0; i < 4; i++) do_upd(7, 1'b0);
    drain();
    expect_pred("sat_lo4", 7);
    for (int i = 0; i < 3; i++) do_upd(7, 1'b0);
    do_upd(7, 1'b1);
    drain();
    expect_pred("sat_lo_then_t", 7);
  endtask

  task automatic test_order;
    int idxs [8] = '{8, 4, 9, 4, 10, 4, 11, 12};
    bit tks [8];
    for (int i = 0; i < 8; i++) tks[i] = 1'($urandom);
    tks[1] = 1'b1;
    tks[3] = 1'b0;
    tks[5] = 1'b0;
    ref_tbl[4] = 3;
    do_upd(4, 1'b1);
    drain();
    upd_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      upd_idx = 4'(idxs[i]);
      upd_taken = tks[i];
      checks++;
      if (upd_ready !== 1'b1) begin
        errs++;
        $display("FAIL order_upd_ready step %0d: upd_ready=%b required 1", i, upd_ready);
      end
      if (upd_ready) ref_tbl[idxs[i]] = sat(ref_tbl[idxs[i]], tks[i]);
      cyc();
    end
    upd_valid = 1'b0;
    drain();
    expect_pred("order_idx4", 4);
    for (int i = 8; i < 13; i++) expect_pred("order_burst", i);
  endtask

  task automatic test_bypass;
    logic req;
    ref_tbl[2] = 3;
    do_upd(2, 1'b1);
    do_upd(2, 1'b0);
    drain();
    upd_valid = 1'b1;
    upd_idx = 4'd2;
    upd_taken = 1'b0;
    cyc();
    upd_valid = 1'b0;
    pred_valid = 1'b1;
    pred_idx = 4'd2;
    cyc();
    pred_valid = 1'b0;
`ifdef BPRED_BYPASS_EN
    req = 1'b0;
`else
    req = 1'b1;
`endif
    checks++;
    if (pred_resp_valid !== 1'b1 || pred_taken !== req) begin
      errs++;
      $display("FAIL bypass: resp_valid=%b pred_taken=%b required 1/%b", pred_resp_valid, pred_taken, req);
    end
    ref_tbl[2] = sat(ref_tbl[2], 1'b0);
    drain();
    expect_pred("bypass_after", 2);
  endtask

  task automatic test_back_to_back;
    pred_valid = 1'b1;
    pred_idx = 4'd0;
    cyc();
    for (int i = 1; i <= 16; i++) begin
      checks++;
      if (pred_resp_valid !== 1'b1 || pred_taken !== logic'(ref_tbl[i-1] >= 2)) begin
        errs++;
        $display("FAIL b2b idx=%0d: resp_valid=%b pred_taken=%b required 1/%b", i - 1,
                 pred_resp_valid, pred_taken, ref_tbl[i-1] >= 2);
      end
      if (i == 16) pred_valid = 1'b0;
      else pred_idx = 4'(i);
      cyc();
    end
    checks++;
    if (pred_resp_valid !== 1'b0 || pred_taken !== logic'(ref_tbl[15] >= 2)) begin
      errs++;
      $display("FAIL b2b_hold: resp_valid=%b pred_taken=%b required 0/%b", pred_resp_valid,
               pred_taken, ref_tbl[15] >= 2);
    end
  endtask

  task automatic test_random;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 30; c++) begin
        upd_valid = 1'($urandom);
        upd_idx = 4'($urandom_range(0, 15));
        upd_taken = 1'($urandom);
        if (upd_valid && upd_ready) ref_tbl[upd_idx] = sat(ref_tbl[upd_idx], upd_taken);
        cyc();
      end
      upd_valid = 1'b0;
      drain();
      check_all("random");
    end
  endtask

  task automatic test_flush;
    do_upd(6, 1'b0);
    do_upd(6, 1'b0);
    drain();
    pred_valid = 1'b1;
    pred_idx = 4'd1;
    upd_valid = 1'b1;
    upd_idx = 4'd6;
    upd_taken = 1'b0;
    cyc();
    pred_valid = 1'b0;
    upd_valid = 1'b0;
    flush = 1'b1;
    #1;
    checks++;
    if (pred_resp_valid !== 1'b1 || pred_ready !== 1'b0 || upd_ready !== 1'b0) begin
      errs++;
      $display("FAIL flush_cycle: resp_valid=%b pred_ready=%b upd_ready=%b required 1/0/0",
               pred_resp_valid, pred_ready, upd_ready);
    end
    cyc();
    flush = 1'b0;
    check_sweep("flush_sweep");
    drain();
    check_all("flush_table");
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    for (int i = 0; i < 5; i++) cyc();
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    check_sweep("flush_in_init");
  endtask

  task automatic test_reset_mid;
    logic t;
    do_pred(0, t);
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    for (int i = 0; i < 6; i++) cyc();
    rst_n = 1'b0;
    #1;
    check_reset_outputs("reset_mid");
    cyc();
    rst_n = 1'b1;
    check_sweep("reset_mid_sweep");
    check_all("reset_mid_table");
  endtask

  initial begin
    ref_fill();
    test_reset();
    test_counter();
    test_saturation();
    test_order();
    test_bypass();
    test_back_to_back();
    test_random();
    test_flush();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
